// File: rtl/dmem_pkg.sv
// Shared types and limits for the handshaked RV32 data memory.
package dmem_pkg;

    localparam int MAX_LATENCY = 15;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store enables/replication, load extension,
// misalignment and illegal-funct3 detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [1:0]  eff_lo;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Low bits are always forced for halfword/word; the trap build turns
    // misalignment into an error upstream so the forced value is never used.
    always_comb begin
        eff_lo = addr_lo;
        if (funct3[1:0] == 2'b01)
            eff_lo = {addr_lo[1], 1'b0};
        else if (funct3[1:0] == 2'b10)
            eff_lo = 2'b00;
    end

    assign sel_byte = rword[{eff_lo, 3'b000} +: 8];
    assign sel_half = rword[{eff_lo[1], 4'b0000} +: 16];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        if (we) begin
            case (funct3)
                F3_SB: begin
                    be        = 4'b0001 << eff_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    misalign  = addr_lo[0];
                    be        = eff_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_rep = {2{wdata[15:0]}};
                end
                F3_SW: begin
                    misalign  = |addr_lo;
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:  rdata_ext = {{24{sel_byte[7]}}, sel_byte};
                F3_LH: begin
                    misalign  = addr_lo[0];
                    rdata_ext = {{16{sel_half[15]}}, sel_half};
                end
                F3_LW: begin
                    misalign  = |addr_lo;
                    rdata_ext = rword;
                end
                F3_LBU: rdata_ext = {24'h0, sel_byte};
                F3_LHU: begin
                    misalign  = addr_lo[0];
                    rdata_ext = {16'h0, sel_half};
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked data memory with configurable access latency.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses error instead of aligning.
//
// state  | meaning
// S_IDLE | ready for a request
// S_BUSY | latency countdown; access commits when counter reaches 0
// S_RESP | response held until consumer handshake
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int         WORDS  = 1 << (DM_ADDRESS - 2);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e                state, state_nxt;
    logic [3:0]            cnt;
    logic                  commit;
    logic                  cap_we;
    logic [DM_ADDRESS-1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic [2:0]            cap_funct3;
    logic [DM_ADDRESS-3:0] idx;
    logic [31:0]           mem [WORDS];
    logic [31:0]           rword;
    logic [3:0]            be;
    logic [31:0]           wdata_rep;
    logic [31:0]           rdata_ext;
    logic                  misalign;
    logic                  illegal;
    logic                  err;

    assign idx   = cap_addr[DM_ADDRESS-1:2];
    assign rword = mem[idx];

    dmem_lane_align u_align (
        .we        (cap_we),
        .funct3    (cap_funct3),
        .addr_lo   (cap_addr[1:0]),
        .wdata     (cap_wdata),
        .rword     (rword),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .misalign  (misalign),
        .illegal   (illegal)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err = illegal | misalign;
`else
    assign err = illegal;
    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= 32'h0;
            cap_funct3 <= 3'b000;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                cap_we     <= req_we;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                cap_funct3 <= req_funct3;
                cnt        <= LAT_M1;
            end else if (state == S_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_rdata <= err ? 32'h0 : rdata_ext;
                rsp_err   <= err;
            end
        end
    end

    // Storage is deliberately outside the reset domain; writes only at commit.
    always_ff @(posedge clk) begin
        if (commit && cap_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (LATENCY=3, DM_ADDRESS=9).
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_w010;

    always #5 clk = ~clk;

    dmem_ctrl #(.DM_ADDRESS(9), .LATENCY(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic issue(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 40) begin @(negedge clk); guard++; end
        req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic do_req(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd, output logic er,
                          output int lat);
        issue(we, addr, wd, f3);
        wait_rsp(lat);
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h expected 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b expected 0", rsp_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, rd, er, lat);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL sw_latency got %0d expected 3", lat); end
        n_checks++; if ({er, rd} !== 33'h0) begin n_fail++; $display("FAIL sw_rsp got err=%b data=%h expected err=0 data=0", er, rd); end
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL lw_latency got %0d expected 3", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_010 got %h err=%b expected deadbeef err=0", rd, er); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 9'h013, 32'h12345680, 3'b000, rd, er, lat);
        do_req(1'b0, 9'h013, 32'h0, 3'b000, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_013 got %h expected ffffff80", rd); end
        do_req(1'b0, 9'h013, 32'h0, 3'b100, rd, er, lat);
        n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_013 got %h expected 00000080", rd); end
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        n_checks++; if (rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL lw_after_sb got %h expected 80adbeef", rd); end
        do_req(1'b0, 9'h011, 32'h0, 3'b000, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFFFBE) begin n_fail++; $display("FAIL lb_011 got %h expected ffffffbe", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 9'h020, 32'hCAFE5678, 3'b010, rd, er, lat);
        do_req(1'b1, 9'h022, 32'hAAAA1234, 3'b001, rd, er, lat);
        do_req(1'b0, 9'h022, 32'h0, 3'b001, rd, er, lat);
        n_checks++; if (rd !== 32'h00001234) begin n_fail++; $display("FAIL lh_022 got %h expected 00001234", rd); end
        do_req(1'b0, 9'h020, 32'h0, 3'b101, rd, er, lat);
        n_checks++; if (rd !== 32'h00005678) begin n_fail++; $display("FAIL lhu_020 got %h expected 00005678", rd); end
        do_req(1'b1, 9'h020, 32'h00008001, 3'b001, rd, er, lat);
        do_req(1'b0, 9'h020, 32'h0, 3'b001, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_neg got %h expected ffff8001", rd); end
        do_req(1'b0, 9'h020, 32'h0, 3'b010, rd, er, lat);
        n_checks++; if (rd !== 32'h12348001) begin n_fail++; $display("FAIL lw_020 got %h expected 12348001", rd); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic er; int lat;
        logic [31:0] exp_lw; logic exp_er; logic [31:0] exp_lh;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_lw = 32'h0; exp_er = 1'b1; exp_lh = 32'h0;
`else
        exp_lw = 32'h80ADBEEF; exp_er = 1'b0; exp_lh = 32'h00001234;
`endif
        do_req(1'b0, 9'h011, 32'h0, 3'b010, rd, er, lat);
        n_checks++; if (rd !== exp_lw || er !== exp_er) begin n_fail++; $display("FAIL lw_misaligned got %h err=%b expected %h err=%b", rd, er, exp_lw, exp_er); end
        do_req(1'b0, 9'h023, 32'h0, 3'b001, rd, er, lat);
        n_checks++; if (rd !== exp_lh || er !== exp_er) begin n_fail++; $display("FAIL lh_misaligned got %h err=%b expected %h err=%b", rd, er, exp_lh, exp_er); end
        do_req(1'b1, 9'h012, 32'h11111111, 3'b010, rd, er, lat);
        n_checks++; if (er !== exp_er || rd !== 32'h0) begin n_fail++; $display("FAIL sw_misaligned got %h err=%b expected 0 err=%b", rd, er, exp_er); end
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_w010 = 32'h80ADBEEF;
`else
        exp_w010 = 32'h11111111;
`endif
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        n_checks++; if (rd !== exp_w010) begin n_fail++; $display("FAIL lw_after_misaligned_sw got %h expected %h", rd, exp_w010); end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 9'h010, 32'h0, 3'b011, rd, er, lat);
        n_checks++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL illegal_load got %h err=%b expected 0 err=1", rd, er); end
        do_req(1'b1, 9'h010, 32'h0, 3'b100, rd, er, lat);
        n_checks++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL illegal_store got %h err=%b expected 0 err=1", rd, er); end
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        n_checks++; if (rd !== exp_w010 || er !== 1'b0) begin n_fail++; $display("FAIL no_write_on_illegal got %h err=%b expected %h err=0", rd, er, exp_w010); end
        do_req(1'b0, 9'h1F0, 32'h0, 3'b111, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL illegal_load_111 got err=%b expected 1", er); end
    endtask

    task automatic test_backpressure;
        int lat; int bad = 0;
        issue(1'b0, 9'h020, 32'h0, 3'b010);
        wait_rsp(lat);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h020;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12348001 || req_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable got %0d bad cycles expected 0", bad); end
        rsp_ready = 1'b1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL handshake_req_ready got %b expected 0", req_ready); end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL release_idle got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready); end
    endtask

    task automatic test_reset_busy;
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 9'h010, 32'h0, 3'b010);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_busy got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid); end
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        n_checks++; if (rd !== exp_w010) begin n_fail++; $display("FAIL store_abandoned got %h expected %h", rd, exp_w010); end
        issue(1'b0, 9'h020, 32'h0, 3'b010);
        wait_rsp(lat);
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_resp got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        exp_w010 = 32'h80ADBEEF;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_illegal();
        test_backpressure();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
